ewrapper_link_tx_arb: RTL and testbench
=======================================

EWRAPPER_LINK_TX_ARB -- requirements
Module: ewrapper_link_tx_arb

Interface
REQ-001 Parameter MAX_BURST, default 8, SHALL set the maximum consecutive beats one requester may hold the grant while burst lock is active (legal range 1..16).
REQ-002 clk  input  1  single clock of the block; the emesh transmit-side clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 a_access, a_write  input  1 each  requester A transaction valid and write flag.
REQ-005 a_datamode  input  2 / a_ctrlmode  input  4 / a_dstaddr, a_srcaddr, a_data  input  32 each  requester A fields.
REQ-006 b_access, b_write, b_datamode, b_ctrlmode, b_dstaddr, b_srcaddr, b_data  input  same widths as REQ-004/005  requester B.
REQ-007 a_wr_wait, a_rd_wait, b_wr_wait, b_rd_wait  output  1 each  per-requester backpressure.
REQ-008 emesh_access_outb, emesh_write_outb  output  1 / emesh_datamode_outb  output  2 / emesh_ctrlmode_outb  output  4 / emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb  output  32  merged stream to the link transmitter.
REQ-009 emesh_wr_wait_inb, emesh_rd_wait_inb  input  1 each  transmitter backpressure.
REQ-010 burst_en  input  1  enables burst lock.

Function
REQ-011 A requester's transaction SHALL be accepted in a cycle where its access=1 and its applicable wait (wr_wait if write=1, else rd_wait) is 0; the requester holds all fields stable while waiting.
REQ-012 Downstream block: writes blocked when emesh_wr_wait_inb=1, reads blocked when emesh_rd_wait_inb=1; the blocked type SHALL NOT be granted in that cycle.
REQ-013 Eligible = access=1 and its type not blocked; grant selection combinational from eligibility, state, and registered last-grant pointer.
REQ-014 Round-robin: both eligible -> grant the requester not granted last; pointer updates on every acceptance; pointer resets to B (A wins first tie).
REQ-015 x_wr_wait = ~(grant==x) | emesh_wr_wait_inb; x_rd_wait = ~(grant==x) | emesh_rd_wait_inb; at most one requester accepted per cycle.
REQ-016 Accepted fields SHALL be registered to emesh_*_outb with 1-cycle latency; emesh_access_outb=1 for exactly one cycle per acceptance, else 0; field outputs hold last value when access_outb=0.
REQ-017 FSM states IDLE, LOCK_A, LOCK_B.
REQ-018 IDLE -> LOCK_x when burst_en=1 and a write is accepted from x with datamode=2'b11 (double).
REQ-019 LOCK_x: only x may be granted; beat counter (4 bits) increments per accepted beat from x.
REQ-020 LOCK_x -> IDLE when counter reaches MAX_BURST, x presents access=0 or a non-write, x's dstaddr != previous dstaddr+8, or burst_en=0; exit evaluated in the cycle of the event, and the other requester is arbitrable in that same cycle.
REQ-021 Blocked downstream during LOCK_x SHALL hold state and counter unchanged.
REQ-022 dstaddr+8 comparison SHALL use 32-bit modular arithmetic (0xFFFFFFF8 -> 0x00000000 is sequential).

Reset
REQ-023 On reset_n=0 asynchronously: state IDLE, counter 0, pointer B, emesh_access_outb=0, all emesh field outputs 0.
REQ-024 Reset mid-burst or mid-acceptance SHALL drop any in-flight beat; no access_outb pulse for it after release.
REQ-025 During reset all four per-requester wait outputs SHALL read 1.

Structure
REQ-026 Shared package SHALL hold FSM state encoding, datamode constant DM_DOUBLE=2'b11, and address stride constant 8.
REQ-027 One sub-module ewrapper_rr_arb2 (2-input round-robin grant with pointer) SHALL be used; FSM, counter, and output register stay in the top.

Verification
REQ-028 A and B both write continuously, burst_en=0 -> outputs alternate A,B,A,B; first beat A.
REQ-029 burst_en=1, A streams 12 double writes dst 0x100,0x108,...; B writes constantly -> 8 A beats, 1 B beat, then A resumes.
REQ-030 A read pending, emesh_rd_wait_inb=1; B write pending -> B accepted, a_rd_wait=1; rd_wait drops -> A accepted next cycle.
REQ-031 LOCK_A, A dst jumps 0x108 -> 0x200 -> lock exits that cycle; next grant follows round-robin.
REQ-032 LOCK_A, emesh_wr_wait_inb=1 for 5 cycles -> no output pulses, counter frozen, lock held; resumes without losing a beat.
REQ-033 reset_n low during beat 3 of a burst -> access_outb=0 immediately; after release state IDLE, first tie goes to A.

Source files
------------

// File: rtl/ewrapper_link_tx_arb_pkg.sv
// ewrapper_link_tx_arb_pkg: shared FSM encoding, emesh constants and transaction struct
package ewrapper_link_tx_arb_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOCK_A = 2'd1;
  localparam logic [1:0] ST_LOCK_B = 2'd2;
  localparam logic [1:0] DM_DOUBLE = 2'b11;
  localparam logic [31:0] ADDR_STRIDE = 32'd8;
  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } emesh_txn_t;
endpackage

// File: rtl/ewrapper_rr_arb2.sv
// ewrapper_rr_arb2: two-input round-robin grant with registered last-grant pointer
module ewrapper_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_b;
  assign gnt[0] = req[0] & (~req[1] | last_b);
  assign gnt[1] = req[1] & (~req[0] | ~last_b);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_b <= 1'b1;
    else if (|gnt) last_b <= gnt[1];
endmodule

// File: rtl/ewrapper_link_tx_arb.sv
// ewrapper_link_tx_arb: merges two emesh requesters onto the link transmitter with
// round-robin arbitration and optional burst lock for sequential double writes
module ewrapper_link_tx_arb
  import ewrapper_link_tx_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_access,
  input  logic        a_write,
  input  logic [1:0]  a_datamode,
  input  logic [3:0]  a_ctrlmode,
  input  logic [31:0] a_dstaddr,
  input  logic [31:0] a_srcaddr,
  input  logic [31:0] a_data,
  input  logic        b_access,
  input  logic        b_write,
  input  logic [1:0]  b_datamode,
  input  logic [3:0]  b_ctrlmode,
  input  logic [31:0] b_dstaddr,
  input  logic [31:0] b_srcaddr,
  input  logic [31:0] b_data,
  output logic        a_wr_wait,
  output logic        a_rd_wait,
  output logic        b_wr_wait,
  output logic        b_rd_wait,
  output logic        emesh_access_outb,
  output logic        emesh_write_outb,
  output logic [1:0]  emesh_datamode_outb,
  output logic [3:0]  emesh_ctrlmode_outb,
  output logic [31:0] emesh_dstaddr_outb,
  output logic [31:0] emesh_srcaddr_outb,
  output logic [31:0] emesh_data_outb,
  input  logic        emesh_wr_wait_inb,
  input  logic        emesh_rd_wait_inb,
  input  logic        burst_en
);
  emesh_txn_t a_txn, b_txn, sel_txn, lock_txn, out_q;
  logic [1:0] state, state_nxt, req, gnt;
  logic [3:0] cnt, cnt_nxt;
  logic a_elig, b_elig, locked, lock_b, lock_acc, lock_elig, lock_blk, lock_exit, open, acc, enter;
  assign a_txn = {a_write, a_datamode, a_ctrlmode, a_dstaddr, a_srcaddr, a_data};
  assign b_txn = {b_write, b_datamode, b_ctrlmode, b_dstaddr, b_srcaddr, b_data};
  assign a_elig = a_access & ~(a_write ? emesh_wr_wait_inb : emesh_rd_wait_inb);
  assign b_elig = b_access & ~(b_write ? emesh_wr_wait_inb : emesh_rd_wait_inb);
  assign locked = state != ST_IDLE;
  assign lock_b = state == ST_LOCK_B;
  assign lock_acc = lock_b ? b_access : a_access;
  assign lock_elig = lock_b ? b_elig : a_elig;
  assign lock_txn = lock_b ? b_txn : a_txn;
  // a downstream stall freezes the lock; otherwise any break releases it this same cycle
  assign lock_blk = lock_acc & ~lock_elig;
  assign lock_exit = locked & ~lock_blk & ((cnt == 4'(MAX_BURST - 1)) | ~lock_acc | ~lock_txn.write |
                     (lock_txn.dstaddr != out_q.dstaddr + ADDR_STRIDE) | ~burst_en);
  assign open = ~locked | lock_exit;
  assign req = {b_elig & (open | lock_b), a_elig & (open | state == ST_LOCK_A)} & {2{reset_n}};
  ewrapper_rr_arb2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );
  assign acc = |gnt;
  assign sel_txn = gnt[1] ? b_txn : a_txn;
  assign enter = acc & burst_en & sel_txn.write & (sel_txn.datamode == DM_DOUBLE);
  assign state_nxt = open ? (enter ? (gnt[1] ? ST_LOCK_B : ST_LOCK_A) : ST_IDLE) : state;
  assign cnt_nxt = open ? 4'd0 : cnt + {3'd0, acc};
  assign a_wr_wait = ~gnt[0] | emesh_wr_wait_inb;
  assign a_rd_wait = ~gnt[0] | emesh_rd_wait_inb;
  assign b_wr_wait = ~gnt[1] | emesh_wr_wait_inb;
  assign b_rd_wait = ~gnt[1] | emesh_rd_wait_inb;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt <= 4'd0;
      emesh_access_outb <= 1'b0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      emesh_access_outb <= acc;
      if (acc) out_q <= sel_txn;
    end
  assign emesh_write_outb = out_q.write;
  assign emesh_datamode_outb = out_q.datamode;
  assign emesh_ctrlmode_outb = out_q.ctrlmode;
  assign emesh_dstaddr_outb = out_q.dstaddr;
  assign emesh_srcaddr_outb = out_q.srcaddr;
  assign emesh_data_outb = out_q.data;
endmodule

// File: tb/tb_ewrapper_link_tx_arb.sv
// tb_ewrapper_link_tx_arb: directed stimulus with a scoreboard of expected link beats
module tb_ewrapper_link_tx_arb;
  typedef struct packed {
    logic        write;
    logic [1:0]  dm;
    logic [3:0]  ctrl;
    logic [31:0] dst;
    logic [31:0] src;
    logic [31:0] data;
  } txn_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic a_access, a_write, b_access, b_write;
  logic [1:0] a_datamode, b_datamode, emesh_datamode_outb;
  logic [3:0] a_ctrlmode, b_ctrlmode, emesh_ctrlmode_outb;
  logic [31:0] a_dstaddr, a_srcaddr, a_data, b_dstaddr, b_srcaddr, b_data;
  logic [31:0] emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb;
  logic a_wr_wait, a_rd_wait, b_wr_wait, b_rd_wait;
  logic emesh_access_outb, emesh_write_outb;
  logic emesh_wr_wait_inb, emesh_rd_wait_inb, burst_en;
  txn_t qa[$], qb[$], exp_q[$];
  int checks = 0, errors = 0;

  ewrapper_link_tx_arb #(.MAX_BURST(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_access(a_access), .a_write(a_write), .a_datamode(a_datamode), .a_ctrlmode(a_ctrlmode),
    .a_dstaddr(a_dstaddr), .a_srcaddr(a_srcaddr), .a_data(a_data),
    .b_access(b_access), .b_write(b_write), .b_datamode(b_datamode), .b_ctrlmode(b_ctrlmode),
    .b_dstaddr(b_dstaddr), .b_srcaddr(b_srcaddr), .b_data(b_data),
    .a_wr_wait(a_wr_wait), .a_rd_wait(a_rd_wait), .b_wr_wait(b_wr_wait), .b_rd_wait(b_rd_wait),
    .emesh_access_outb(emesh_access_outb), .emesh_write_outb(emesh_write_outb),
    .emesh_datamode_outb(emesh_datamode_outb), .emesh_ctrlmode_outb(emesh_ctrlmode_outb),
    .emesh_dstaddr_outb(emesh_dstaddr_outb), .emesh_srcaddr_outb(emesh_srcaddr_outb),
    .emesh_data_outb(emesh_data_outb),
    .emesh_wr_wait_inb(emesh_wr_wait_inb), .emesh_rd_wait_inb(emesh_rd_wait_inb),
    .burst_en(burst_en)
  );

  always #5 clk = ~clk;

  function automatic txn_t mk(input logic w, input logic [1:0] dm, input logic [31:0] dst, input logic [31:0] tag);
    txn_t t;
    t.write = w;
    t.dm = dm;
    t.ctrl = tag[3:0];
    t.dst = dst;
    t.src = tag ^ 32'hA5A5_0000;
    t.data = tag;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic present();
    a_access = qa.size() != 0;
    b_access = qb.size() != 0;
    if (qa.size() != 0) {a_write, a_datamode, a_ctrlmode, a_dstaddr, a_srcaddr, a_data} = qa[0];
    if (qb.size() != 0) {b_write, b_datamode, b_ctrlmode, b_dstaddr, b_srcaddr, b_data} = qb[0];
  endtask

  // requester model: a transaction is retired when access is high and its wait is low at the edge
  task automatic cycle();
    logic ta, tb;
    @(negedge clk);
    ta = a_access && !(a_write ? a_wr_wait : a_rd_wait);
    tb = b_access && !(b_write ? b_wr_wait : b_rd_wait);
    @(posedge clk);
    #1;
    if (ta) void'(qa.pop_front());
    if (tb) void'(qb.pop_front());
    present();
  endtask

  task automatic run(input int max);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL run_timeout: %0d A and %0d B requests pending after %0d cycles, expected 0", qa.size(), qb.size(), n);
      qa.delete();
      qb.delete();
      present();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    txn_t got, e;
    if (reset_n && emesh_access_outb) begin
      got = {emesh_write_outb, emesh_datamode_outb, emesh_ctrlmode_outb, emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got dst %h data %h, expected no beat", got.dst, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got w%0b dm%0d dst %h src %h data %h, expected w%0b dm%0d dst %h src %h data %h",
                   got.write, got.dm, got.dst, got.src, got.data, e.write, e.dm, e.dst, e.src, e.data);
        end
      end
    end
  end

  initial begin
    {a_write, a_datamode, a_ctrlmode, a_dstaddr, a_srcaddr, a_data} = '0;
    {b_write, b_datamode, b_ctrlmode, b_dstaddr, b_srcaddr, b_data} = '0;
    emesh_wr_wait_inb = 1'b0;
    emesh_rd_wait_inb = 1'b0;
    burst_en = 1'b0;
    a_access = 1'b1;
    a_write = 1'b1;
    b_access = 1'b1;
    #12;
    chk("rst_access_outb", 32'(emesh_access_outb), 32'd0);
    chk("rst_dstaddr_outb", emesh_dstaddr_outb, 32'd0);
    chk("rst_data_outb", emesh_data_outb, 32'd0);
    chk("rst_a_wr_wait", 32'(a_wr_wait), 32'd1);
    chk("rst_a_rd_wait", 32'(a_rd_wait), 32'd1);
    chk("rst_b_wr_wait", 32'(b_wr_wait), 32'd1);
    chk("rst_b_rd_wait", 32'(b_rd_wait), 32'd1);
    present();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // both writing, no burst: strict alternation starting with A
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(1'b1, 2'b10, 32'h1000 + 32'(8 * i), 32'hA100 + 32'(i)));
      qb.push_back(mk(1'b1, 2'b10, 32'h2000 + 32'(8 * i), 32'hB100 + 32'(i)));
      exp_q.push_back(qa[i]);
      exp_q.push_back(qb[i]);
    end
    present();
    run(40);
    // burst lock: 8 A beats, one B, A re-locks
    burst_en = 1'b1;
    for (int i = 0; i < 12; i++) qa.push_back(mk(1'b1, 2'b11, 32'h100 + 32'(8 * i), 32'hA200 + 32'(i)));
    for (int i = 0; i < 4; i++) qb.push_back(mk(1'b1, 2'b10, 32'h2100 + 32'(8 * i), 32'hB200 + 32'(i)));
    for (int i = 0; i < 8; i++) exp_q.push_back(qa[i]);
    exp_q.push_back(qb[0]);
    for (int i = 8; i < 12; i++) exp_q.push_back(qa[i]);
    for (int i = 1; i < 4; i++) exp_q.push_back(qb[i]);
    present();
    run(60);
    // read blocked downstream, write from B goes first
    burst_en = 1'b0;
    emesh_rd_wait_inb = 1'b1;
    qa.push_back(mk(1'b0, 2'b10, 32'h3000, 32'hA300));
    qb.push_back(mk(1'b1, 2'b10, 32'h3100, 32'hB300));
    exp_q.push_back(qb[0]);
    exp_q.push_back(qa[0]);
    present();
    #1;
    chk("rdblk_a_rd_wait", 32'(a_rd_wait), 32'd1);
    chk("rdblk_b_wr_wait", 32'(b_wr_wait), 32'd0);
    cycle();
    #1;
    chk("rdblk_a_rd_wait_alone", 32'(a_rd_wait), 32'd1);
    cycle();
    emesh_rd_wait_inb = 1'b0;
    #1;
    chk("rdfree_a_rd_wait", 32'(a_rd_wait), 32'd0);
    run(10);
    // address jump breaks the lock; B wins the same cycle
    burst_en = 1'b1;
    qa.push_back(mk(1'b1, 2'b11, 32'h100, 32'hA400));
    qa.push_back(mk(1'b1, 2'b11, 32'h108, 32'hA401));
    qa.push_back(mk(1'b1, 2'b11, 32'h200, 32'hA402));
    qa.push_back(mk(1'b1, 2'b11, 32'h208, 32'hA403));
    exp_q.push_back(qa[0]);
    exp_q.push_back(qa[1]);
    exp_q.push_back(mk(1'b1, 2'b10, 32'h4100, 32'hB400));
    exp_q.push_back(qa[2]);
    exp_q.push_back(qa[3]);
    present();
    cycle();
    qb.push_back(mk(1'b1, 2'b10, 32'h4100, 32'hB400));
    present();
    run(20);
    // downstream write stall inside a lock
    for (int i = 0; i < 10; i++) qa.push_back(mk(1'b1, 2'b11, 32'h300 + 32'(8 * i), 32'hA500 + 32'(i)));
    for (int i = 0; i < 8; i++) exp_q.push_back(qa[i]);
    exp_q.push_back(mk(1'b1, 2'b10, 32'h5100, 32'hB500));
    exp_q.push_back(qa[8]);
    exp_q.push_back(qa[9]);
    exp_q.push_back(mk(1'b1, 2'b10, 32'h5108, 32'hB501));
    present();
    cycle();
    qb.push_back(mk(1'b1, 2'b10, 32'h5100, 32'hB500));
    qb.push_back(mk(1'b1, 2'b10, 32'h5108, 32'hB501));
    present();
    cycle();
    cycle();
    emesh_wr_wait_inb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_a_wr_wait", 32'(a_wr_wait), 32'd1);
      chk("stall_b_wr_wait", 32'(b_wr_wait), 32'd1);
      if (i > 0) chk("stall_no_beat", 32'(emesh_access_outb), 32'd0);
      cycle();
    end
    emesh_wr_wait_inb = 1'b0;
    chk("stall_end_no_beat", 32'(emesh_access_outb), 32'd0);
    run(40);
    // reset during beat 3 of a burst drops it
    for (int i = 0; i < 6; i++) qa.push_back(mk(1'b1, 2'b11, 32'h400 + 32'(8 * i), 32'hA600 + 32'(i)));
    exp_q.push_back(qa[0]);
    exp_q.push_back(qa[1]);
    present();
    cycle();
    cycle();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_access_outb", 32'(emesh_access_outb), 32'd0);
    chk("midrst_dstaddr_outb", emesh_dstaddr_outb, 32'd0);
    chk("midrst_a_wr_wait", 32'(a_wr_wait), 32'd1);
    chk("midrst_b_rd_wait", 32'(b_rd_wait), 32'd1);
    qa.delete();
    qb.delete();
    present();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    burst_en = 1'b0;
    qa.push_back(mk(1'b1, 2'b10, 32'h6000, 32'hA700));
    qb.push_back(mk(1'b1, 2'b10, 32'h6100, 32'hB700));
    exp_q.push_back(qa[0]);
    exp_q.push_back(qb[0]);
    present();
    run(10);
    // address wrap at the top of the 32-bit space stays sequential
    burst_en = 1'b1;
    qa.push_back(mk(1'b1, 2'b11, 32'hFFFF_FFF0, 32'hA800));
    qa.push_back(mk(1'b1, 2'b11, 32'hFFFF_FFF8, 32'hA801));
    qa.push_back(mk(1'b1, 2'b11, 32'h0000_0000, 32'hA802));
    qa.push_back(mk(1'b1, 2'b11, 32'h0000_0008, 32'hA803));
    for (int i = 0; i < 4; i++) exp_q.push_back(qa[i]);
    exp_q.push_back(mk(1'b1, 2'b10, 32'h7100, 32'hB800));
    present();
    cycle();
    qb.push_back(mk(1'b1, 2'b10, 32'h7100, 32'hB800));
    present();
    run(20);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
